// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared definitions for the VGA/XGA timing generator:
//   - default counter width
//   - default timing for mode 0 (XGA 1024x768) and mode 1 (SVGA 800x600)
//   - helpers deriving line/frame totals and sync window bounds
//   - mode and FSM state enumerations
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    localparam int DEFAULT_CNT_W = 11;

    // Mode 0: XGA 1024x768 (1344 x 806 total)
    localparam int XGA_H_ACTIVE  = 1024;
    localparam int XGA_H_FP      = 24;
    localparam int XGA_H_SYNC    = 136;
    localparam int XGA_H_BP      = 160;
    localparam int XGA_V_ACTIVE  = 768;
    localparam int XGA_V_FP      = 3;
    localparam int XGA_V_SYNC    = 6;
    localparam int XGA_V_BP      = 29;

    // Mode 1: SVGA 800x600 (1056 x 628 total)
    localparam int SVGA_H_ACTIVE = 800;
    localparam int SVGA_H_FP     = 40;
    localparam int SVGA_H_SYNC   = 128;
    localparam int SVGA_H_BP     = 88;
    localparam int SVGA_V_ACTIVE = 600;
    localparam int SVGA_V_FP     = 1;
    localparam int SVGA_V_SYNC   = 4;
    localparam int SVGA_V_BP     = 23;

    typedef enum logic {
        MODE_XGA  = 1'b0,
        MODE_SVGA = 1'b1
    } mode_e;

    typedef enum logic {
        RUN_M0 = 1'b0,
        RUN_M1 = 1'b1
    } state_e;

    // Number of counts in one axis period (line or frame).
    function automatic int axis_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First count inside the sync window.
    function automatic int sync_first(input int active, input int fp);
        return active + fp;
    endfunction

    // First count past the sync window (exclusive bound).
    function automatic int sync_stop(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
// One timing axis (horizontal or vertical). Counts 0..total-1 on each step,
// and registers blank / sync-active decoded from the next count, so the
// registered count, blank and sync always describe the same position.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   step            advance the count this cycle
//   clear           force the next count to 0
//   total           period length (count wraps at total-1)
//   active          blank asserted for count >= active
//   sync_start      first count of the sync window
//   sync_end        first count past the sync window
//   count           registered count
//   count_nxt       value count takes on the next edge
//   blank           registered blank
//   blank_nxt       value blank takes on the next edge
//   sync_act        registered sync window flag (before polarity)
//   wrap            combinational: this step wraps count to 0
//
// total/step select the current period; active/sync_* describe the period the
// next count belongs to. They differ only on the cycle a mode change lands.
// -----------------------------------------------------------------------------
module vga_axis_counter #(
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             clear,
    input  logic [CNT_W:0]   total,
    input  logic [CNT_W:0]   active,
    input  logic [CNT_W:0]   sync_start,
    input  logic [CNT_W:0]   sync_end,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt,
    output logic             blank,
    output logic             blank_nxt,
    output logic             sync_act,
    output logic             wrap
);

    localparam logic [CNT_W:0]   ONE_W = 1;
    localparam logic [CNT_W-1:0] ONE_C = 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             blank_q, blank_d;
    logic             sync_q, sync_d;

    assign wrap = step && ({1'b0, count_q} == (total - ONE_W));

    always_comb begin
        // NOTE: default assignment first so every path drives count_d; without it an incomplete if would infer a latch.
        count_d = count_q;
        if (clear || wrap) begin
            count_d = '0;
        end else if (step) begin
            count_d = count_q + ONE_C;
        end
    end

    always_comb begin
        blank_d = ({1'b0, count_d} >= active);
        sync_d  = ({1'b0, count_d} >= sync_start) && ({1'b0, count_d} < sync_end);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking (<=) for all state so every flop samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            count_q <= '0;
            blank_q <= 1'b0;
            sync_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            blank_q <= blank_d;
            sync_q  <= sync_d;
        end
    end

    assign count     = count_q;
    assign count_nxt = count_d;
    assign blank     = blank_q;
    assign blank_nxt = blank_d;
    assign sync_act  = sync_q;

endmodule

// File: rtl/vga_timing_gen.sv
// -----------------------------------------------------------------------------
// vga_timing_gen
// Two-mode VGA/XGA timing generator. Mode 0 / mode 1 timing is parameterised;
// the requested mode is sampled only on the last pixel of a frame so every
// frame is complete. All outputs are registered from next-state values, so
// they all describe the same pixel in the same cycle.
//
// Ports:
//   pclk         pixel clock (rising edge)
//   rst_n        asynchronous active-low reset
//   en           pixel enable; low holds all state and outputs
//   mode_sel     requested mode, sampled at end of frame
//   mode         mode currently generated (0 = XGA timing, 1 = SVGA timing)
//   hcount       pixel within line
//   vcount       line within frame
//   hsync/vsync  sync outputs, active level HSYNC_POL / VSYNC_POL
//   hblnk/vblnk  blanking (count >= active length)
//   de           data enable (~hblnk & ~vblnk)
//   line_start   high while hcount = 0 after a wrap
//   frame_start  high while hcount = vcount = 0 after a wrap
//   frame_cnt    (only with VGA_TIMING_FRAME_CNT_EN) frames started since reset
//
// Build option: define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_cnt.
// -----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   CNT_W       = DEFAULT_CNT_W,
    parameter int   M0_H_ACTIVE = XGA_H_ACTIVE,
    parameter int   M0_H_FP     = XGA_H_FP,
    parameter int   M0_H_SYNC   = XGA_H_SYNC,
    parameter int   M0_H_BP     = XGA_H_BP,
    parameter int   M0_V_ACTIVE = XGA_V_ACTIVE,
    parameter int   M0_V_FP     = XGA_V_FP,
    parameter int   M0_V_SYNC   = XGA_V_SYNC,
    parameter int   M0_V_BP     = XGA_V_BP,
    parameter int   M1_H_ACTIVE = SVGA_H_ACTIVE,
    parameter int   M1_H_FP     = SVGA_H_FP,
    parameter int   M1_H_SYNC   = SVGA_H_SYNC,
    parameter int   M1_H_BP     = SVGA_H_BP,
    parameter int   M1_V_ACTIVE = SVGA_V_ACTIVE,
    parameter int   M1_V_FP     = SVGA_V_FP,
    parameter int   M1_V_SYNC   = SVGA_V_SYNC,
    parameter int   M1_V_BP     = SVGA_V_BP,
    parameter logic HSYNC_POL   = 1'b1,
    parameter logic VSYNC_POL   = 1'b1
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             mode_sel,
    output logic             mode,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             hblnk,
    output logic             vblnk,
    output logic             de,
    output logic             line_start,
`ifdef VGA_TIMING_FRAME_CNT_EN
    output logic [15:0]      frame_cnt,
`endif
    output logic             frame_start
);

    localparam int BW = CNT_W + 1;

    localparam logic [CNT_W:0] M0_HT  = BW'(axis_total(M0_H_ACTIVE, M0_H_FP, M0_H_SYNC, M0_H_BP));
    localparam logic [CNT_W:0] M0_HA  = BW'(M0_H_ACTIVE);
    localparam logic [CNT_W:0] M0_HSF = BW'(sync_first(M0_H_ACTIVE, M0_H_FP));
    localparam logic [CNT_W:0] M0_HSS = BW'(sync_stop(M0_H_ACTIVE, M0_H_FP, M0_H_SYNC));
    localparam logic [CNT_W:0] M0_VT  = BW'(axis_total(M0_V_ACTIVE, M0_V_FP, M0_V_SYNC, M0_V_BP));
    localparam logic [CNT_W:0] M0_VA  = BW'(M0_V_ACTIVE);
    localparam logic [CNT_W:0] M0_VSF = BW'(sync_first(M0_V_ACTIVE, M0_V_FP));
    localparam logic [CNT_W:0] M0_VSS = BW'(sync_stop(M0_V_ACTIVE, M0_V_FP, M0_V_SYNC));

    localparam logic [CNT_W:0] M1_HT  = BW'(axis_total(M1_H_ACTIVE, M1_H_FP, M1_H_SYNC, M1_H_BP));
    localparam logic [CNT_W:0] M1_HA  = BW'(M1_H_ACTIVE);
    localparam logic [CNT_W:0] M1_HSF = BW'(sync_first(M1_H_ACTIVE, M1_H_FP));
    localparam logic [CNT_W:0] M1_HSS = BW'(sync_stop(M1_H_ACTIVE, M1_H_FP, M1_H_SYNC));
    localparam logic [CNT_W:0] M1_VT  = BW'(axis_total(M1_V_ACTIVE, M1_V_FP, M1_V_SYNC, M1_V_BP));
    localparam logic [CNT_W:0] M1_VA  = BW'(M1_V_ACTIVE);
    localparam logic [CNT_W:0] M1_VSF = BW'(sync_first(M1_V_ACTIVE, M1_V_FP));
    localparam logic [CNT_W:0] M1_VSS = BW'(sync_stop(M1_V_ACTIVE, M1_V_FP, M1_V_SYNC));

    state_e state_q, state_d;

    logic de_q, de_d;
    logic line_start_q, line_start_d;
    logic frame_start_q, frame_start_d;

    // Period lengths follow the mode being generated now; window decode
    // follows the mode of the next pixel, which differs only on a switch.
    logic [CNT_W:0] h_total, v_total;
    logic [CNT_W:0] h_active, h_sync_first, h_sync_stop;
    logic [CNT_W:0] v_active, v_sync_first, v_sync_stop;

    logic [CNT_W-1:0] h_count, h_count_nxt, v_count, v_count_nxt;
    logic             h_blank, h_blank_nxt, v_blank, v_blank_nxt;
    logic             h_sync_act, v_sync_act;
    logic             h_wrap, v_wrap;
    logic             mode_clear;

    always_comb begin
        h_total = M0_HT;
        v_total = M0_VT;
        if (state_q == RUN_M1) begin
            h_total = M1_HT;
            v_total = M1_VT;
        end
    end

    always_comb begin
        h_active     = M0_HA;
        h_sync_first = M0_HSF;
        h_sync_stop  = M0_HSS;
        v_active     = M0_VA;
        v_sync_first = M0_VSF;
        v_sync_stop  = M0_VSS;
        if (state_d == RUN_M1) begin
            h_active     = M1_HA;
            h_sync_first = M1_HSF;
            h_sync_stop  = M1_HSS;
            v_active     = M1_VA;
            v_sync_first = M1_VSF;
            v_sync_stop  = M1_VSS;
        end
    end

    // v_wrap already implies en and the horizontal wrap: it is exactly the
    // last pixel of the frame, the only point where mode_sel is looked at.
    always_comb begin
        state_d = state_q;
        if (v_wrap) begin
            state_d = mode_sel ? RUN_M1 : RUN_M0;
        end
    end

    // Both counters wrap to 0 on this cycle anyway; the clear makes the
    // restart at (0,0) explicit whenever the period length changes.
    assign mode_clear = v_wrap && (state_d != state_q);

    vga_axis_counter #(.CNT_W(CNT_W)) u_h_axis (
        .clk        (pclk),
        .rst_n      (rst_n),
        .step       (en),
        .clear      (mode_clear),
        .total      (h_total),
        .active     (h_active),
        .sync_start (h_sync_first),
        .sync_end   (h_sync_stop),
        .count      (h_count),
        .count_nxt  (h_count_nxt),
        .blank      (h_blank),
        .blank_nxt  (h_blank_nxt),
        .sync_act   (h_sync_act),
        .wrap       (h_wrap)
    );

    vga_axis_counter #(.CNT_W(CNT_W)) u_v_axis (
        .clk        (pclk),
        .rst_n      (rst_n),
        .step       (h_wrap),
        .clear      (mode_clear),
        .total      (v_total),
        .active     (v_active),
        .sync_start (v_sync_first),
        .sync_end   (v_sync_stop),
        .count      (v_count),
        .count_nxt  (v_count_nxt),
        .blank      (v_blank),
        .blank_nxt  (v_blank_nxt),
        .sync_act   (v_sync_act),
        .wrap       (v_wrap)
    );

    // Strobes hold their value while en is low instead of dropping. Counters
    // never return to 0 except by wrapping, so reset itself never strobes.
    always_comb begin
        de_d          = !h_blank_nxt && !v_blank_nxt;
        line_start_d  = line_start_q;
        frame_start_d = frame_start_q;
        if (en) begin
            line_start_d  = (h_count_nxt == '0);
            frame_start_d = (h_count_nxt == '0) && (v_count_nxt == '0);
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= RUN_M0;
            de_q          <= 1'b1;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (en && frame_start_d) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
`endif

    // Polarity is a constant, so these are plain wires/inverters on flop outputs.
    assign hsync       = HSYNC_POL ? h_sync_act : !h_sync_act;
    assign vsync       = VSYNC_POL ? v_sync_act : !v_sync_act;
    assign mode        = (state_q == RUN_M1) ? MODE_SVGA : MODE_XGA;
    assign hcount      = h_count;
    assign vcount      = v_count;
    assign hblnk       = h_blank;
    assign vblnk       = v_blank;
    assign de          = de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_timing_gen
// Two generator instances with reduced timing share one stimulus: dut uses
// active-high syncs, dut_n active-low syncs. The reference model keeps a
// linear pixel index within the frame plus the current mode and derives
// every output from it with division/modulo and window arithmetic.
// -----------------------------------------------------------------------------
module tb_vga_timing_gen;

    localparam int CW = 11;
    //                          mode0 mode1
    localparam int HA [2] = '{16, 12};
    localparam int HF [2] = '{2,  1};
    localparam int HS [2] = '{3,  2};
    localparam int HB [2] = '{4,  3};
    localparam int VA [2] = '{10, 8};
    localparam int VF [2] = '{1,  2};
    localparam int VS [2] = '{2,  1};
    localparam int VB [2] = '{3,  2};

    logic pclk     = 1'b0;
    logic rst_n    = 1'b0;
    logic en       = 1'b0;
    logic mode_sel = 1'b0;

    logic          mode, hsync, vsync, hblnk, vblnk, de, line_start, frame_start;
    logic [CW-1:0] hcount, vcount;
    logic          mode_n, hsync_n, vsync_n, hblnk_n, vblnk_n, de_n, line_start_n, frame_start_n;
    logic [CW-1:0] hcount_n, vcount_n;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]   frame_cnt, frame_cnt_n;
`endif

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit m_mode;
    int m_p;
    bit m_stepped;
    int m_frames;

    always #5 pclk = ~pclk;

    vga_timing_gen #(
        .CNT_W(CW),
        .M0_H_ACTIVE(HA[0]), .M0_H_FP(HF[0]), .M0_H_SYNC(HS[0]), .M0_H_BP(HB[0]),
        .M0_V_ACTIVE(VA[0]), .M0_V_FP(VF[0]), .M0_V_SYNC(VS[0]), .M0_V_BP(VB[0]),
        .M1_H_ACTIVE(HA[1]), .M1_H_FP(HF[1]), .M1_H_SYNC(HS[1]), .M1_H_BP(HB[1]),
        .M1_V_ACTIVE(VA[1]), .M1_V_FP(VF[1]), .M1_V_SYNC(VS[1]), .M1_V_BP(VB[1]),
        .HSYNC_POL(1'b1), .VSYNC_POL(1'b1)
    ) dut (
        .pclk(pclk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
        .mode(mode), .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .hblnk(hblnk), .vblnk(vblnk), .de(de), .line_start(line_start),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(frame_cnt),
`endif
        .frame_start(frame_start)
    );

    vga_timing_gen #(
        .CNT_W(CW),
        .M0_H_ACTIVE(HA[0]), .M0_H_FP(HF[0]), .M0_H_SYNC(HS[0]), .M0_H_BP(HB[0]),
        .M0_V_ACTIVE(VA[0]), .M0_V_FP(VF[0]), .M0_V_SYNC(VS[0]), .M0_V_BP(VB[0]),
        .M1_H_ACTIVE(HA[1]), .M1_H_FP(HF[1]), .M1_H_SYNC(HS[1]), .M1_H_BP(HB[1]),
        .M1_V_ACTIVE(VA[1]), .M1_V_FP(VF[1]), .M1_V_SYNC(VS[1]), .M1_V_BP(VB[1]),
        .HSYNC_POL(1'b0), .VSYNC_POL(1'b0)
    ) dut_n (
        .pclk(pclk), .rst_n(rst_n), .en(en), .mode_sel(mode_sel),
        .mode(mode_n), .hcount(hcount_n), .vcount(vcount_n), .hsync(hsync_n), .vsync(vsync_n),
        .hblnk(hblnk_n), .vblnk(vblnk_n), .de(de_n), .line_start(line_start_n),
`ifdef VGA_TIMING_FRAME_CNT_EN
        .frame_cnt(frame_cnt_n),
`endif
        .frame_start(frame_start_n)
    );

    // ---------------- reference model ----------------
    function automatic int ht(input bit m);
        return HA[m] + HF[m] + HS[m] + HB[m];
    endfunction

    function automatic int vt(input bit m);
        return VA[m] + VF[m] + VS[m] + VB[m];
    endfunction

    task automatic model_reset();
        m_mode    = 1'b0;
        m_p       = 0;
        m_stepped = 1'b0;
        m_frames  = 0;
    endtask

    // Expected {mode,hcount,vcount,hsync,vsync,hblnk,vblnk,de,line_start,frame_start};
    // inv selects the active-low sync instance.
    function automatic logic [29:0] exp_vec(input bit inv);
        int h, v;
        bit hs, vs, hb, vb;
        h  = m_p % ht(m_mode);
        v  = m_p / ht(m_mode);
        hs = (h >= HA[m_mode] + HF[m_mode]) && (h < HA[m_mode] + HF[m_mode] + HS[m_mode]);
        vs = (v >= VA[m_mode] + VF[m_mode]) && (v < VA[m_mode] + VF[m_mode] + VS[m_mode]);
        hb = (h >= HA[m_mode]);
        vb = (v >= VA[m_mode]);
        return {m_mode, CW'(h), CW'(v), hs ^ inv, vs ^ inv, hb, vb, !hb && !vb,
                m_stepped && (h == 0), m_stepped && (m_p == 0)};
    endfunction

    function automatic logic [59:0] exp_all();
        return {exp_vec(1'b0), exp_vec(1'b1)};
    endfunction

    function automatic logic [59:0] act_all();
        return {mode, hcount, vcount, hsync, vsync, hblnk, vblnk, de, line_start, frame_start,
                mode_n, hcount_n, vcount_n, hsync_n, vsync_n, hblnk_n, vblnk_n, de_n,
                line_start_n, frame_start_n};
    endfunction

    // Called at a negedge: drive inputs, advance DUT and model by one edge,
    // return at the following negedge where outputs are sampled.
    task automatic tick(input bit e, input bit s);
        en       = e;
        mode_sel = s;
        @(posedge pclk);
        if (e) begin
            m_stepped = 1'b1;
            if (m_p == ht(m_mode) * vt(m_mode) - 1) begin
                m_p      = 0;
                m_mode   = s;
                m_frames = m_frames + 1;
            end else begin
                m_p = m_p + 1;
            end
        end
        @(negedge pclk);
    endtask

    task automatic do_reset(input bit s);
        rst_n    = 1'b0;
        en       = 1'b0;
        mode_sel = s;
        @(negedge pclk);
        @(negedge pclk);
        model_reset();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        @(negedge pclk);
        model_reset();
        checks++;
        if (act_all() !== exp_all()) begin
            errors++;
            $display("FAIL reset_values: got %h expected %h", act_all(), exp_all());
        end
        checks++;
        if ({hsync_n, vsync_n, hsync, vsync, de} !== 5'b11001) begin
            errors++;
            $display("FAIL reset_sync_levels: got %b expected 11001", {hsync_n, vsync_n, hsync, vsync, de});
        end
        do_reset(1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1'b0, 1'b0);
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL reset_hold_en_low: got %h expected %h", act_all(), exp_all());
            end
        end
    endtask

    task automatic test_mode0_frames();
        int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, fs_cnt = 0, last_fs = -1, period = 0;
        int hs_min = 9999, hs_max = -1, vs_min = 9999, vs_max = -1, h_max = 0, v_max = 0;
        do_reset(1'b0);
        for (int i = 0; i < 2 * ht(0) * vt(0); i++) begin
            tick(1'b1, 1'b0);
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL mode0_cycle %0d: got %h expected %h", i, act_all(), exp_all());
            end
            if (hsync) begin
                hs_cnt++;
                if (int'(hcount) < hs_min) hs_min = int'(hcount);
                if (int'(hcount) > hs_max) hs_max = int'(hcount);
            end
            if (vsync) begin
                vs_cnt++;
                if (int'(vcount) < vs_min) vs_min = int'(vcount);
                if (int'(vcount) > vs_max) vs_max = int'(vcount);
            end
            if (de_n) de_cnt++;
            if (int'(hcount) > h_max) h_max = int'(hcount);
            if (int'(vcount) > v_max) v_max = int'(vcount);
            if (frame_start) begin
                fs_cnt++;
                if (last_fs >= 0) period = i - last_fs;
                last_fs = i;
            end
        end
        checks++;
        if (hs_cnt != 2 * vt(0) * HS[0] || hs_min != HA[0] + HF[0] || hs_max != HA[0] + HF[0] + HS[0] - 1) begin
            errors++;
            $display("FAIL mode0_hsync_window: got cnt=%0d span %0d..%0d expected cnt=%0d span %0d..%0d",
                     hs_cnt, hs_min, hs_max, 2 * vt(0) * HS[0], HA[0] + HF[0], HA[0] + HF[0] + HS[0] - 1);
        end
        checks++;
        if (vs_cnt != 2 * ht(0) * VS[0] || vs_min != VA[0] + VF[0] || vs_max != VA[0] + VF[0] + VS[0] - 1) begin
            errors++;
            $display("FAIL mode0_vsync_window: got cnt=%0d span %0d..%0d expected cnt=%0d span %0d..%0d",
                     vs_cnt, vs_min, vs_max, 2 * ht(0) * VS[0], VA[0] + VF[0], VA[0] + VF[0] + VS[0] - 1);
        end
        checks++;
        if (h_max != ht(0) - 1 || v_max != vt(0) - 1) begin
            errors++;
            $display("FAIL mode0_wrap_points: got h=%0d v=%0d expected h=%0d v=%0d", h_max, v_max, ht(0) - 1, vt(0) - 1);
        end
        checks++;
        if (fs_cnt != 2 || period != ht(0) * vt(0)) begin
            errors++;
            $display("FAIL mode0_frame_period: got pulses=%0d period=%0d expected pulses=2 period=%0d",
                     fs_cnt, period, ht(0) * vt(0));
        end
        checks++;
        if (de_cnt != 2 * HA[0] * VA[0]) begin
            errors++;
            $display("FAIL de_active_count: got %0d expected %0d", de_cnt, 2 * HA[0] * VA[0]);
        end
    endtask

    task automatic test_mode_switch();
        int h_max = 0, v_max = 0, hb_first = -1;
        do_reset(1'b1);
        for (int i = 0; i < ht(0) * vt(0); i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL switch_frame1 cycle %0d: got %h expected %h", i, act_all(), exp_all());
            end
        end
        checks++;
        if ({mode, frame_start, hcount, vcount} !== {1'b1, 1'b1, {CW{1'b0}}, {CW{1'b0}}}) begin
            errors++;
            $display("FAIL switch_boundary: got mode=%b fs=%b h=%0d v=%0d expected mode=1 fs=1 h=0 v=0",
                     mode, frame_start, hcount, vcount);
        end
        for (int i = 0; i < ht(1) * vt(1); i++) begin
            tick(1'b1, 1'b1);
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL switch_frame2 cycle %0d: got %h expected %h", i, act_all(), exp_all());
            end
            if (int'(hcount) > h_max) h_max = int'(hcount);
            if (int'(vcount) > v_max) v_max = int'(vcount);
            if (hblnk && hb_first < 0) hb_first = int'(hcount);
        end
        checks++;
        if (h_max != ht(1) - 1 || v_max != vt(1) - 1 || hb_first != HA[1]) begin
            errors++;
            $display("FAIL mode1_geometry: got hmax=%0d vmax=%0d hblnk_at=%0d expected %0d %0d %0d",
                     h_max, v_max, hb_first, ht(1) - 1, vt(1) - 1, HA[1]);
        end
    endtask

    task automatic test_mode_glitch();
        int fs_cnt = 0, bad_mode = 0;
        bit s;
        // Starts at (0,0) in mode 1; mode_sel dips to 0 around line 4 only.
        for (int i = 0; i < ht(1) * vt(1); i++) begin
            s = !((i >= 4 * ht(1)) && (i < 5 * ht(1)));
            tick(1'b1, s);
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL glitch_cycle %0d: got %h expected %h", i, act_all(), exp_all());
            end
            if (frame_start) fs_cnt++;
            if (mode !== 1'b1) bad_mode++;
        end
        checks++;
        if (fs_cnt != 1 || bad_mode != 0) begin
            errors++;
            $display("FAIL glitch_no_effect: got fs=%0d wrong_mode=%0d expected fs=1 wrong_mode=0", fs_cnt, bad_mode);
        end
    endtask

    task automatic test_en_hold();
        int target = HA[1] + HF[1] - 1;
        for (int i = 0; i < 4 * ht(1) && hcount !== CW'(target); i++) tick(1'b1, 1'b1);
        checks++;
        if (hcount !== CW'(target)) begin
            errors++;
            $display("FAIL hold_reach_target: got h=%0d expected %0d", hcount, target);
        end
        for (int i = 0; i < 50; i++) begin
            tick(1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL hold_frozen cycle %0d: got %h expected %h", i, act_all(), exp_all());
            end
        end
        tick(1'b1, 1'b1);
        checks++;
        if ({hsync, hsync_n, hcount} !== {1'b1, 1'b0, CW'(target + 1)}) begin
            errors++;
            $display("FAIL hold_resume_hsync: got hs=%b hs_n=%b h=%0d expected 1 0 %0d", hsync, hsync_n, hcount, target + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            checks++;
            if (act_all() !== exp_all()) begin
                errors++;
                $display("FAIL random_cycle %0d: got %h expected %h", i, act_all(), exp_all());
            end
`ifdef VGA_TIMING_FRAME_CNT_EN
            checks++;
            if (frame_cnt !== 16'(m_frames)) begin
                errors++;
                $display("FAIL random_frame_cnt %0d: got %0d expected %0d", i, frame_cnt, m_frames);
            end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 1000 && vcount !== CW'(5); i++) tick(1'b1, 1'b0);
        checks++;
        if (vcount !== CW'(5)) begin
            errors++;
            $display("FAIL async_reach_line: got v=%0d expected 5", vcount);
        end
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (act_all() !== exp_all()) begin
            errors++;
            $display("FAIL async_reset_immediate: got %h expected %h", act_all(), exp_all());
        end
        @(negedge pclk);
        rst_n = 1'b1;
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd0 || frame_cnt_n !== 16'd0) begin
            errors++;
            $display("FAIL frame_cnt_reset: got %0d/%0d expected 0", frame_cnt, frame_cnt_n);
        end
`endif
        for (int i = 0; i < 3 * ht(0) * vt(0) + 3; i++) tick(1'b1, 1'b0);
        checks++;
        if (act_all() !== exp_all()) begin
            errors++;
            $display("FAIL after_reset_three_frames: got %h expected %h", act_all(), exp_all());
        end
`ifdef VGA_TIMING_FRAME_CNT_EN
        checks++;
        if (frame_cnt !== 16'd3) begin
            errors++;
            $display("FAIL frame_cnt_three: got %0d expected 3", frame_cnt);
        end
`endif
    endtask

    initial begin
        model_reset();
        test_reset();
        test_mode0_frames();
        test_mode_switch();
        test_mode_glitch();
        test_en_hold();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised, two-mode VGA/XGA timing generator. It drives the pixel counters, sync, blanking and data-enable signals consumed by the draw/overlay pipeline. It supports a runtime choice of two resolutions, switched only at frame boundaries, plus a pixel-clock enable and frame/line start strobes.

Parameters:
CNT_W, 11, width of hcount/vcount; every M*_H_TOTAL and M*_V_TOTAL must be <= 2**CNT_W.
M0_H_ACTIVE / M0_H_FP / M0_H_SYNC / M0_H_BP, 1024/24/136/160, mode 0 horizontal timing in pixels (total 1344).
M0_V_ACTIVE / M0_V_FP / M0_V_SYNC / M0_V_BP, 768/3/6/29, mode 0 vertical timing in lines (total 806).
M1_H_ACTIVE / M1_H_FP / M1_H_SYNC / M1_H_BP, 800/40/128/88, mode 1 horizontal timing (total 1056).
M1_V_ACTIVE / M1_V_FP / M1_V_SYNC / M1_V_BP, 600/1/4/23, mode 1 vertical timing (total 628).
HSYNC_POL, 1'b1, active level of hsync.
VSYNC_POL, 1'b1, active level of vsync.

Ports:
pclk  in  1  pixel clock; all logic is on the rising edge.
rst_n  in  1  asynchronous, active-low reset.
en  in  1  pixel enable; while low, all state and outputs hold.
mode_sel  in  1  requested mode (0 or 1); sampled only at the end of a frame.
mode  out  1  mode currently being generated.
hcount  out  CNT_W  pixel index within the line.
vcount  out  CNT_W  line index within the frame.
hsync  out  1  horizontal sync, polarity set by HSYNC_POL.
vsync  out  1  vertical sync, polarity set by VSYNC_POL.
hblnk  out  1  high when hcount >= H_ACTIVE.
vblnk  out  1  high when vcount >= V_ACTIVE.
de  out  1  data enable = ~hblnk & ~vblnk.
line_start  out  1  one-cycle pulse when hcount is 0.
frame_start  out  1  one-cycle pulse when hcount and vcount are both 0.

Behaviour:
- All outputs are registered. Every output is computed from the next-state counters, so all outputs refer to the same pixel in the same cycle (zero skew between outputs).
- Reset (asynchronous assert, synchronous-safe deassert):
  - hcount = 0, vcount = 0, mode = 0.
  - hblnk = 0, vblnk = 0, de = 1.
  - hsync = ~HSYNC_POL, vsync = ~VSYNC_POL.
  - line_start = 0, frame_start = 0.
- When en = 1, each cycle:
  - hcount increments and wraps from H_TOTAL-1 to 0.
  - On that horizontal wrap, vcount increments and wraps from V_TOTAL-1 to 0.
- When en = 0: counters, mode and all outputs hold; the start strobes also hold (they are not forced low).
- Sync windows:
  - hsync is active for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], exactly H_SYNC pixels.
  - vsync is active for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], exactly V_SYNC full lines.
- Mode state machine, states RUN_M0 and RUN_M1:
  - mode_sel is sampled only in the cycle where hcount = H_TOTAL-1, vcount = V_TOTAL-1 and en = 1.
  - The new mode, its timing and the counter wrap to (0,0) all take effect on the next edge.
  - mode_sel changes at any other time have no effect. If mode_sel equals the current mode, the wrap is normal.
- After a mode change the counters always restart at (0,0) and frame_start pulses; a partial frame is never emitted.
- Strobe timing:
  - frame_start is asserted in the cycle the counters show (0,0) after a wrap, never straight after reset.
  - line_start is asserted whenever hcount = 0 after a wrap.
- Arithmetic: window bounds are constants of CNT_W+1 bits; comparisons are unsigned. No counter reaches 2**CNT_W.
- Reset mid-frame: the asynchronous return to reset values is immediate. The first line after reset runs in mode 0.

Optional Feature:
VGA_TIMING_FRAME_CNT_EN:
- Defined: adds output frame_cnt [15:0]. It resets to 0, increments (with wrap) on every cycle where frame_start is asserted and en = 1, and holds while en = 0.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Decomposition:
- Package vga_timing_pkg holds:
  - the mode 0 and mode 1 timing constants and derived totals/window bounds;
  - the mode enumeration (MODE_XGA = 0, MODE_SVGA = 1);
  - the default CNT_W.
- Sub-module vga_axis_counter: one per axis. It takes a total, sync-start and sync-end, active length, a step enable and a force-clear. It outputs count, blank, sync-active (before polarity) and wrap. The top module instantiates it twice (horizontal stepped by en, vertical stepped by horizontal wrap) and adds the mode FSM, polarity, de and strobes.

Test Plan:
- Reset then run mode 0 for 2 frames:
  - hsync active for hcount 1048..1183 (136 cycles);
  - vsync active for lines 771..776 (6 lines);
  - hcount wraps at 1343, vcount at 805;
  - frame period 1083264 cycles.
- Reset with mode_sel = 1: frame 1 is mode 0. At the end of the frame, mode → 1 and frame_start pulses; then hblnk is set at hcount ≥ 800, hsync spans 840..967, wrap at 1055/627.
- Toggle mode_sel mid-frame (vcount = 300) and back before the frame end: the mode never changes and there is no extra frame_start.
- Hold en low for 50 cycles at hcount = 1047: all outputs are frozen; when en returns high, hsync asserts on the next cycle at hcount = 1048.
- Build with HSYNC_POL = 0 and VSYNC_POL = 0: after reset hsync = vsync = 1, and both go low only inside their windows. de is 1 exactly for the 1024×768 active pixels per frame.
- Assert rst_n low mid-frame (vcount = 500), asynchronously between edges: the outputs go to their reset values before the next pclk edge. With VGA_TIMING_FRAME_CNT_EN, frame_cnt reads 0 after reset and 3 after three frame wraps.
